// File: rtl/sra_srl_iterative_if.sv
// Start/ready bundle for the iterative right shifter.
// The master drives requests; the slave returns the result.
interface sra_srl_iterative_if #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
);
    logic               ctrl_SHIFT;
    logic               ctrl_arith;
    logic [WIDTH-1:0]   data_operandA;
    logic [SHAMT_W-1:0] ctrl_shiftamt;
    logic [WIDTH-1:0]   data_result;
    logic               data_resultRDY;
    logic               busy;

    modport master (
        output ctrl_SHIFT,
        output ctrl_arith,
        output data_operandA,
        output ctrl_shiftamt,
        input  data_result,
        input  data_resultRDY,
        input  busy
    );

    modport slave (
        input  ctrl_SHIFT,
        input  ctrl_arith,
        input  data_operandA,
        input  ctrl_shiftamt,
        output data_result,
        output data_resultRDY,
        output busy
    );
endinterface

// File: rtl/sra_srl_iterative.sv
// Multicycle SRL/SRA unit: one power-of-two stage per clock,
// highest stage first, fixed latency of SHAMT_W cycles.
module sra_srl_iterative #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input  logic                 clock,
    input  logic                 reset,
    sra_srl_iterative_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    localparam logic [SHAMT_W-1:0] LAST = SHAMT_W'(SHAMT_W - 1);

    state_t             state_q;
    logic [WIDTH-1:0]   work_q;
    logic [WIDTH-1:0]   work_d;
    logic [WIDTH-1:0]   res_q;
    logic [SHAMT_W-1:0] amt_q;
    logic [SHAMT_W-1:0] cnt_q;
    logic               fill_q;
    logic               rdy_q;
    logic               busy_q;

    // Each stage is a fixed-distance slice with the latched fill bit
    logic [WIDTH-1:0] stage_w [SHAMT_W];

    for (genvar k = 0; k < SHAMT_W; k++) begin : g_stage
        localparam int D = 1 << k;
        assign stage_w[k] = {{D{fill_q}}, work_q[WIDTH-1:D]};
    end

    // Pick the stage selected by the counter, apply it if its amount bit is set
    always_comb begin
        work_d = work_q;
        for (int k = 0; k < SHAMT_W; k++) begin
            if (cnt_q == SHAMT_W'(k) && amt_q[k]) begin
                work_d = stage_w[k];
            end
        end
    end

    // Control FSM with registered outputs and working registers
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= IDLE;
            work_q  <= '0;
            res_q   <= '0;
            amt_q   <= '0;
            cnt_q   <= '0;
            fill_q  <= 1'b0;
            rdy_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    rdy_q <= 1'b0;
                    if (bus.ctrl_SHIFT) begin
                        work_q  <= bus.data_operandA;
                        amt_q   <= bus.ctrl_shiftamt;
                        fill_q  <= bus.ctrl_arith
                                 & bus.data_operandA[WIDTH-1];
                        cnt_q   <= LAST;
                        busy_q  <= 1'b1;
                        state_q <= SHIFT;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                SHIFT: begin
                    work_q <= work_d;
                    cnt_q  <= cnt_q - SHAMT_W'(1);
                    if (cnt_q == '0) begin
                        res_q   <= work_d;
                        rdy_q   <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= DONE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    rdy_q   <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.data_result    = res_q;
    assign bus.data_resultRDY = rdy_q;
    assign bus.busy           = busy_q;

endmodule

// File: doc/sra_srl_iterative.md
Name: sra_srl_iterative

Overview:
- Multicycle right-shift unit for the ALU.
- Provides the right-direction counterpart to the combinational left barrel shifter.
- Computes logical (SRL) or arithmetic (SRA) right shift by resolving one power-of-two stage per clock, 16, 8, 4, 2, then 1.
- Uses a start/ready handshake like the multdiv unit, so the pipeline can stall on it.

Parameters:
WIDTH, 32, operand/result width in bits
SHAMT_W, 5, shift-amount width; number of stages (must satisfy 2^SHAMT_W == WIDTH)

Ports:
clock  input  1  system clock, rising edge
reset  input  1  synchronous, active-low reset
ctrl_SHIFT  input  1  start request, sampled each rising edge
ctrl_arith  input  1  1 = arithmetic (sign fill), 0 = logical (zero fill); sampled with ctrl_SHIFT
data_operandA  input  WIDTH  value to shift; sampled with ctrl_SHIFT
ctrl_shiftamt  input  SHAMT_W  shift amount 0..WIDTH-1; sampled with ctrl_SHIFT
data_result  output  WIDTH  shifted result; valid while data_resultRDY=1, held until next accepted start
data_resultRDY  output  1  one-cycle pulse marking result valid
busy  output  1  high while an operation is in flight (SHIFT state)

Behaviour:
- Reset (reset==0 at a rising edge):
  - state=IDLE; data_result=0; data_resultRDY=0; busy=0; internal operand/amount/stage registers cleared.
  - Reset overrides everything, including a start in the same cycle and an operation in flight; the aborted op produces no RDY pulse.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - ctrl_SHIFT=1 at edge E0 latches operand, amount and arith into working registers.
  - Stage counter set to SHAMT_W-1 (stage 4); go to SHIFT; busy=1 from E0.
- SHIFT:
  - At each edge, if amount bit[k] is 1, working value = working >> 2^k, filled with the latched sign bit (arith=1) or 0 (arith=0); otherwise unchanged.
  - Counter decrements at each edge.
  - After stage 0 is applied (edge E5 for SHAMT_W=5), the value is copied to data_result; go to DONE; busy=0.
  - ctrl_SHIFT while in SHIFT is ignored, with no queueing and no corruption.
- DONE:
  - data_resultRDY=1 for exactly this one cycle.
  - Next edge returns to IDLE, unless ctrl_SHIFT=1 at that edge, in which case a new op is accepted exactly as from IDLE (back-to-back, no bubble).
- Latency is fixed at SHAMT_W cycles regardless of amount. Start sampled at E0, RDY high between E5 and E6.
- Sign source is bit WIDTH-1 of the operand latched at E0, not the input at later edges. Input changes after E0 have no effect.
- shiftamt=0: result = operand, same latency.
- Maximum shift 31: SRL of 0x80000000 yields 1; SRA yields 0xFFFFFFFF.
- data_result holds its last value through IDLE. It changes only on stage-0 completion or reset.
- Shift is implemented by wiring/muxing per stage plus one register. No multiplier, and no variable shifter operator beyond fixed-distance slices.

Test Plan:
- SRL/SRA basic:
  - operandA=0x80000000, shamt=4, arith=0 -> RDY 5 cycles after start, result 0x08000000.
  - Repeat with arith=1 -> 0xF8000000.
- Extremes:
  - shamt=31, operandA=0x80000000, arith=1 -> 0xFFFFFFFF.
  - arith=0 -> 0x00000001.
  - shamt=0, operandA=0x12345678 -> 0x12345678 after 5 cycles.
- Mixed stages: operandA=0xF0F0F0F0, shamt=21 (16+4+1), arith=1 -> 0xFFFFFF87; busy high exactly 5 cycles, RDY one cycle.
- Start while busy: second ctrl_SHIFT (operandA=0xFFFFFFFF, shamt=1) pulsed 2 cycles into an op -> ignored; first result unaffected; only one RDY pulse.
- Back-to-back: ctrl_SHIFT asserted in the DONE cycle with operandA=0x00000100, shamt=8 -> first RDY observed, second RDY exactly 5 cycles later with 0x00000001.
- Reset mid-op: reset=0 at the cycle-3 edge of an op -> busy=0, data_result=0, no RDY pulse; a new op after reset completes normally.
